// File: rtl/switch_conditioner.sv
// Slide-switch front end: synchronise, debounce, detect edges and publish a
// decoded configuration snapshot to the LED logic over a valid/ack handshake.
module switch_conditioner #(
  parameter int unsigned NUM_SW          = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_clean,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic              cfg_valid,
  input  logic              cfg_ack,
  output logic [NUM_SW-1:0] cfg_word,
  output logic              cfg_run_rst,
  output logic              cfg_speed,
  output logic              cfg_move2,
  output logic [3:0]        cfg_start_pos,
  output logic              cfg_light_up,
  output logic              cfg_overrun,
  output logic              soft_rst_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  logic [NUM_SW-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SW-1:0] sw_sync;
  logic [CW-1:0]     cnt_q  [NUM_SW];
  logic [CW-1:0]     cnt_d  [NUM_SW];
  logic [NUM_SW-1:0] clean_q, clean_d;
  logic [NUM_SW-1:0] rise_q, fall_q;
  logic              chg;
  state_t            state_q;
  logic              valid_q, overrun_q;
  logic [NUM_SW-1:0] word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sw_sync = sync_q[SYNC_STAGES-1];

  // Any cycle where the synced level agrees with the accepted level restarts the count.
  always_comb begin
    clean_d = clean_q;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = '0;
      if (sw_sync[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) clean_d[i] = sw_sync[i];
        else                      cnt_d[i]   = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SW; i++) cnt_q[i] <= cnt_d[i];
      clean_q <= clean_d;
      rise_q  <= clean_d & ~clean_q;
      fall_q  <= ~clean_d & clean_q;
    end
  end

  assign chg = |(rise_q | fall_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      word_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (chg) begin
            word_q  <= clean_q;
            valid_q <= 1'b1;
            state_q <= PENDING;
          end
        end
        PENDING: begin
          // A fresh change always wins over a same-cycle ack; the snapshot stays pending.
          if (chg) begin
            word_q <= clean_q;
            if (!cfg_ack) overrun_q <= 1'b1;
          end else if (cfg_ack) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sw_clean       = clean_q;
  assign sw_rise        = rise_q;
  assign sw_fall        = fall_q;
  assign cfg_valid      = valid_q;
  assign cfg_word       = word_q;
  assign cfg_overrun    = overrun_q;
  assign cfg_run_rst    = word_q[0];
  assign cfg_speed      = word_q[1];
  assign cfg_move2      = word_q[2];
  assign cfg_start_pos  = word_q[6:3];
  assign cfg_light_up   = word_q[7];
  assign soft_rst_pulse = rise_q[0];

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed switch patterns checked against a
// window-based behavioural model every cycle plus hand-computed expectations.
module tb_switch_conditioner;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_raw = '0;
  logic       cfg_ack = 1'b0;
  logic [7:0] sw_clean, sw_rise, sw_fall, cfg_word;
  logic       cfg_valid, cfg_run_rst, cfg_speed, cfg_move2, cfg_light_up;
  logic       cfg_overrun, soft_rst_pulse;
  logic [3:0] cfg_start_pos;

  int n_chk = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  switch_conditioner #(
    .NUM_SW(8),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw_clean(sw_clean),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .cfg_valid(cfg_valid),
    .cfg_ack(cfg_ack),
    .cfg_word(cfg_word),
    .cfg_run_rst(cfg_run_rst),
    .cfg_speed(cfg_speed),
    .cfg_move2(cfg_move2),
    .cfg_start_pos(cfg_start_pos),
    .cfg_light_up(cfg_light_up),
    .cfg_overrun(cfg_overrun),
    .soft_rst_pulse(soft_rst_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: raw samples are seen DEB-wide after SYNC edges of delay; a bit flips
  // once the last DEB seen samples all disagree with its accepted level.
  logic [7:0] m_clean = '0, m_rise = '0, m_fall = '0, m_word = '0;
  logic       m_valid = 1'b0, m_ovr = 1'b0;
  logic [7:0] rawq[$];
  logic [7:0] seenq[$];

  initial begin
    logic [7:0] s, flip;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_clean = '0; m_rise = '0; m_fall = '0; m_word = '0;
        m_valid = 1'b0; m_ovr = 1'b0;
        rawq.delete(); seenq.delete();
      end else begin
        if (|(m_rise | m_fall)) begin
          if (m_valid && !cfg_ack) m_ovr = 1'b1;
          m_word  = m_clean;
          m_valid = 1'b1;
        end else if (cfg_ack) begin
          m_valid = 1'b0;
        end
        s = (rawq.size() >= SYNC) ? rawq[SYNC-1] : 8'h00;
        rawq.push_front(sw_raw);
        if (rawq.size() > SYNC) void'(rawq.pop_back());
        seenq.push_front(s);
        if (seenq.size() > DEB) void'(seenq.pop_back());
        flip = (seenq.size() == DEB) ? 8'hFF : 8'h00;
        foreach (seenq[k]) flip &= seenq[k] ^ m_clean;
        m_rise  = flip & ~m_clean;
        m_fall  = flip & m_clean;
        m_clean = m_clean ^ flip;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && !rst) begin
        chk("clean", sw_clean, m_clean);
        chk("rise", sw_rise, m_rise);
        chk("fall", sw_fall, m_fall);
        chk("valid", 8'(cfg_valid), 8'(m_valid));
        chk("word", cfg_word, m_word);
        chk("overrun", 8'(cfg_overrun), 8'(m_ovr));
        chk("run_rst", 8'(cfg_run_rst), 8'(m_word[0]));
        chk("speed", 8'(cfg_speed), 8'(m_word[1]));
        chk("move2", 8'(cfg_move2), 8'(m_word[2]));
        chk("start_pos", 8'(cfg_start_pos), 8'(m_word[6:3]));
        chk("light_up", 8'(cfg_light_up), 8'(m_word[7]));
        chk("soft_rst", 8'(soft_rst_pulse), 8'(m_rise[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] acc_clean, acc_rise, acc_fall, acc_valid;
    int r7, f7, rff, rother;

    // Reset
    repeat (10) tick();
    chk("rst_clean", sw_clean, 8'h00);
    chk("rst_rise", sw_rise, 8'h00);
    chk("rst_fall", sw_fall, 8'h00);
    chk("rst_valid", 8'(cfg_valid), 8'h00);
    chk("rst_word", cfg_word, 8'h00);
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick();

    // Glitch: bit 1 high for three sampled cycles only
    sw_raw = 8'h02;
    repeat (3) tick();
    sw_raw = 8'h00;
    acc_clean = '0; acc_rise = '0; acc_fall = '0; acc_valid = '0;
    repeat (10) begin
      tick();
      acc_clean |= sw_clean; acc_rise |= sw_rise; acc_fall |= sw_fall;
      acc_valid |= 8'(cfg_valid);
    end
    chk("glitch_clean", acc_clean, 8'h00);
    chk("glitch_rise", acc_rise, 8'h00);
    chk("glitch_fall", acc_fall, 8'h00);
    chk("glitch_valid", acc_valid, 8'h00);

    // Clean step 00 -> 2B
    sw_raw = 8'h2B;
    repeat (5) tick();
    chk("step_early", sw_clean, 8'h00);
    tick();
    chk("step_clean", sw_clean, 8'h2B);
    chk("step_rise", sw_rise, 8'h2B);
    chk("step_soft", 8'(soft_rst_pulse), 8'h01);
    chk("step_valid_lag", 8'(cfg_valid), 8'h00);
    tick();
    chk("step_valid", 8'(cfg_valid), 8'h01);
    chk("step_word", cfg_word, 8'h2B);
    chk("step_pos", 8'(cfg_start_pos), 8'h05);
    chk("step_speed", 8'(cfg_speed), 8'h01);
    chk("step_move2", 8'(cfg_move2), 8'h00);
    chk("step_rise_done", sw_rise, 8'h00);
    cfg_ack = 1'b1;
    tick();
    cfg_ack = 1'b0;
    chk("step_ack", 8'(cfg_valid), 8'h00);

    // Bounce on bit 7, then hold high
    r7 = 0; f7 = 0;
    for (int k = 0; k < 4; k++) begin
      sw_raw[7] = (k % 2 == 0);
      repeat (2) begin
        tick();
        r7 += int'(sw_rise[7]); f7 += int'(sw_fall[7]);
      end
    end
    sw_raw[7] = 1'b1;
    repeat (12) begin
      tick();
      r7 += int'(sw_rise[7]); f7 += int'(sw_fall[7]);
    end
    chk("bounce_rise7", 8'(r7), 8'h01);
    chk("bounce_fall7", 8'(f7), 8'h00);
    chk("bounce_clean", sw_clean, 8'hAB);
    cfg_ack = 1'b1;
    tick();
    cfg_ack = 1'b0;
    chk("bounce_ack", 8'(cfg_valid), 8'h00);

    // Overrun: replace an unacknowledged snapshot
    sw_raw = 8'h80;
    for (int i = 0; i < 20 && !cfg_valid; i++) tick();
    chk("ovr_wait_valid", 8'(cfg_valid), 8'h01);
    chk("ovr_word80", cfg_word, 8'h80);
    sw_raw = 8'h81;
    for (int i = 0; i < 20 && cfg_word != 8'h81; i++) tick();
    chk("ovr_word81", cfg_word, 8'h81);
    chk("ovr_valid", 8'(cfg_valid), 8'h01);
    chk("ovr_flag", 8'(cfg_overrun), 8'h01);
    cfg_ack = 1'b1;
    tick();
    cfg_ack = 1'b0;
    chk("ovr_ack", 8'(cfg_valid), 8'h00);
    repeat (3) tick();
    chk("ovr_sticky", 8'(cfg_overrun), 8'h01);

    // Async reset while bits are mid-debounce
    sw_raw = 8'hFF;
    repeat (4) tick();
    #1 rst = 1'b1;
    #1;
    chk("arst_clean", sw_clean, 8'h00);
    chk("arst_rise", sw_rise, 8'h00);
    chk("arst_valid", 8'(cfg_valid), 8'h00);
    chk("arst_word", cfg_word, 8'h00);
    chk("arst_ovr", 8'(cfg_overrun), 8'h00);
    chk("arst_soft", 8'(soft_rst_pulse), 8'h00);
    rst = 1'b0;
    rff = 0; rother = 0;
    repeat (15) begin
      tick();
      if (sw_rise == 8'hFF) rff++;
      else if (sw_rise != 8'h00) rother++;
    end
    chk("arst_riseFF", 8'(rff), 8'h01);
    chk("arst_rise_other", 8'(rother), 8'h00);
    chk("arst_word_ff", cfg_word, 8'hFF);
    chk("arst_valid_ff", 8'(cfg_valid), 8'h01);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
